// File: rtl/uart_pkg.sv
// Shared definitions for the serial byte link (transmit and receive sides).
// Latency: none, declarations only.
// Backpressure: not applicable.
package uart_pkg;

    // Shifter state encoding, kept identical on both link directions
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS       = 8;
    localparam logic IDLE_LEVEL      = 1'b1;
    localparam logic START_LEVEL     = 1'b0;
    // 27 MHz system clock x 32 us bit period
    localparam int   BIT_CYCLES_32US = 864;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..BIT_CYCLES-1, tick on terminal count, sync clear.
// Latency: tick_o is combinational from the count register; clear acts next edge.
// Backpressure: none, free counting while clr_i is low.
module uart_baud_tick #(
    parameter int BIT_CYCLES = 864
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // last cycle of the bit period, and the cycle just before it
    assign tick_o     = (cnt_q == CW'(BIT_CYCLES - 1));
    assign pre_tick_o = (cnt_q == CW'(BIT_CYCLES - 2));

    // next count: hold at zero while cleared, wrap on terminal count
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1/8N2 serial transmitter with a 1-deep holding register; even parity when UART_TX_PARITY_EN is defined.
// Latency: accepted byte drives the start bit from the 2nd edge after accept; frame = (10+STOP_BITS-1)*BIT_CYCLES.
// Backpressure: ready low while the holding register is full; back-to-back frames have no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_32US,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    uart_state_e          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_full_q;
    logic [2:0]           bit_idx_q;
    logic                 tx_q;
    logic                 done_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    logic baud_clr;
    logic baud_tick;
    logic baud_pre_tick;
    logic accept;
    logic stop_last;
    logic launch;

    // baud counter sits at zero while idle so each start bit is a full period
    assign baud_clr  = (state_q == ST_IDLE);
    assign accept    = valid && !hold_full_q;
    assign stop_last = (bit_idx_q == 3'(STOP_BITS - 1));
    // holding byte moves into the shifter from idle, or straight after the final stop bit
    assign launch    = hold_full_q &&
                       ((state_q == ST_IDLE) ||
                        ((state_q == ST_STOP) && baud_tick && stop_last));

    uart_baud_tick #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (baud_clr),
        .tick_o     (baud_tick),
        .pre_tick_o (baud_pre_tick)
    );

    // frame sequencer with registered line level and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            tx_q        <= IDLE_LEVEL;
            done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                hold_q      <= data;
                hold_full_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    tx_q <= IDLE_LEVEL;
                end
                ST_START: begin
                    if (baud_tick) begin
                        state_q   <= ST_DATA;
                        tx_q      <= shift_q[0];
                        bit_idx_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q   <= ST_PARITY;
                            tx_q      <= parity_q;
`else
                            state_q   <= ST_STOP;
                            tx_q      <= IDLE_LEVEL;
`endif
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (baud_tick) begin
                        state_q   <= ST_STOP;
                        tx_q      <= IDLE_LEVEL;
                        bit_idx_q <= '0;
                    end
                end
`endif
                ST_STOP: begin
                    // registered, so raise it one cycle ahead of the final stop cycle
                    if (baud_pre_tick && stop_last) begin
                        done_q <= 1'b1;
                    end
                    if (baud_tick) begin
                        if (stop_last) begin
                            state_q <= ST_IDLE;
                            tx_q    <= IDLE_LEVEL;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= IDLE_LEVEL;
                end
            endcase
            // a launch overrides the end-of-frame return to idle
            if (launch) begin
                state_q     <= ST_START;
                tx_q        <= START_LEVEL;
                shift_q     <= hold_q;
                bit_idx_q   <= '0;
                hold_full_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_q    <= ^hold_q;
`endif
            end
        end
    end

    assign ready = !hold_full_q;
    assign tx    = tx_q;
    assign busy  = (state_q != ST_IDLE);
    assign done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: two instances (1 and 2 stop bits), scoreboard of expected line patterns.
// Latency: checks start-bit latency, frame length, done position and zero-gap chaining.
// Backpressure: producer holds valid until ready; held byte must vanish on reset.
module tb_uart_tx;

    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data0, data1;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic       tx0, tx1;
    logic       busy0, busy1;
    logic       done0, done1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    string q0[$];
    string q1[$];
    int    frames[2];
    int    frame_end[2];
    int    last_gap[2];

    // hand-derived line patterns in transmit order (start, data LSB first, [parity], stop)
`ifdef UART_TX_PARITY_EN
    string P_A5 = "01010010101";
    string P_00 = "00000000001";
    string P_FF = "01111111101";
    string P_3C = "00011110001";
    string P_81 = "01000000101";
    string P_55 = "010101010011";
    string P_07 = "01110000011";
    string P_03 = "01100000001";
`else
    string P_A5 = "0101001011";
    string P_00 = "0000000001";
    string P_FF = "0111111111";
    string P_3C = "0001111001";
    string P_81 = "0100000011";
    string P_55 = "01010101011";
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx #(.BIT_CYCLES(BC), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .data(data0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
    );

    uart_tx #(.BIT_CYCLES(BC), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .data(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    function automatic logic tx_of(input int u);
        return (u == 0) ? tx0 : tx1;
    endfunction
    function automatic logic done_of(input int u);
        return (u == 0) ? done0 : done1;
    endfunction
    function automatic logic busy_of(input int u);
        return (u == 0) ? busy0 : busy1;
    endfunction
    function automatic logic ready_of(input int u);
        return (u == 0) ? ready0 : ready1;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // monitor: on each start bit pop the expected pattern and compare every line cycle
    task automatic mon(input int u);
        string pat;
        int    n;
        bit    bad, dbad, abort;
        logic  act;
        forever begin
            @(negedge clk);
            if (reset) continue;
            if (tx_of(u) == 1'b0) begin
                last_gap[u] = cyc - frame_end[u] - 1;
                if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL u%0d unexpected_frame: start bit at cycle %0d, expected idle", u, cyc);
                    for (int t = 0; t < 100 && busy_of(u); t++) @(negedge clk);
                    continue;
                end
                pat   = (u == 0) ? q0.pop_front() : q1.pop_front();
                n     = pat.len();
                dbad  = 1'b0;
                abort = 1'b0;
                for (int b = 0; b < n && !abort; b++) begin
                    bad = 1'b0;
                    act = 1'b0;
                    for (int c = 0; c < BC; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (reset) begin
                            abort = 1'b1;
                            break;
                        end
                        if (tx_of(u) !== (pat[b] == "1")) begin
                            bad = 1'b1;
                            act = tx_of(u);
                        end
                        if (done_of(u) !== ((b == n - 1) && (c == BC - 1))) dbad = 1'b1;
                    end
                    if (!abort) begin
                        checks++;
                        if (bad) begin
                            errors++;
                            $display("FAIL u%0d line_bit%0d of %s: got %0b, expected %s", u, b, pat, act, pat.substr(b, b));
                        end
                    end
                end
                if (!abort) begin
                    checks++;
                    if (dbad) begin
                        errors++;
                        $display("FAIL u%0d done_timing of %s: done not high only on cycle %0d of frame", u, pat, n * BC);
                    end
                    frame_end[u] = cyc;
                    frames[u]++;
                end
            end
        end
    endtask

    // producer: hold valid until ready, accept on the next edge
    task automatic send(input int u, input logic [7:0] d, input string pat, input bit push);
        int t = 0;
        if (u == 0) begin data0 = d; valid0 = 1'b1; end
        else        begin data1 = d; valid1 = 1'b1; end
        while (!ready_of(u) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            check("accept_timeout", 1, 0);
        end else begin
            @(posedge clk);
            if (push) begin
                if (u == 0) q0.push_back(pat);
                else        q1.push_back(pat);
            end
            @(negedge clk);
        end
        if (u == 0) valid0 = 1'b0;
        else        valid1 = 1'b0;
    endtask

    // start-bit latency and cycles from first start cycle to done
    task automatic measure(input int u, input int exp_len);
        int lat = 0;
        int len = 1;
        while (tx_of(u) !== 1'b0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("start_latency", lat, 1);
        while (done_of(u) !== 1'b1 && len < 200) begin
            @(negedge clk);
            len++;
        end
        check("frame_length", len, exp_len);
    endtask

    task automatic wait_frames(input int u, input int target);
        int t = 0;
        while (frames[u] < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("frame_count", frames[u], target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_tx, bad_rdy, bad_busy, bad_done;
        frames    = '{0, 0};
        frame_end = '{0, 0};
        last_gap  = '{-1, -1};
        reset  = 1'b1;
        valid0 = 1'b0; valid1 = 1'b0;
        data0  = 8'h00; data1 = 8'h00;
        fork
            mon(0);
            mon(1);
        join_none
        repeat (3) @(negedge clk);
        check("reset_tx", int'(tx0), 1);
        check("reset_ready", int'(ready0), 1);
        reset = 1'b0;

        // idle after reset
        bad_tx = 0; bad_rdy = 0; bad_busy = 0; bad_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || tx1 !== 1'b1)       bad_tx++;
            if (ready0 !== 1'b1 || ready1 !== 1'b1) bad_rdy++;
            if (busy0 !== 1'b0 || busy1 !== 1'b0)   bad_busy++;
            if (done0 !== 1'b0 || done1 !== 1'b0)   bad_done++;
        end
        check("idle_tx_bad_cycles", bad_tx, 0);
        check("idle_ready_bad_cycles", bad_rdy, 0);
        check("idle_busy_bad_cycles", bad_busy, 0);
        check("idle_done_bad_cycles", bad_done, 0);

        // single byte
        send(0, 8'hA5, P_A5, 1'b1);
        measure(0, P_A5.len() * BC);
        @(negedge clk);
        check("busy_after_done", int'(busy0), 0);
        wait_frames(0, 1);

        // back-to-back, second byte waits in the holding register
        send(0, 8'h00, P_00, 1'b1);
        send(0, 8'hFF, P_FF, 1'b1);
        check("ready_low_both_pending", int'(ready0), 0);
        repeat (10) @(negedge clk);
        check("ready_low_mid_frame", int'(ready0), 0);
        wait_frames(0, 3);
        check("zero_gap", last_gap[0], 0);

        // reset during data bit 3, with a byte also held
        send(0, 8'h3C, P_3C, 1'b1);
        send(0, 8'hE7, "", 1'b0);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("reset_mid_tx", int'(tx0), 1);
        check("reset_mid_busy", int'(busy0), 0);
        check("reset_mid_ready", int'(ready0), 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("truncated_frame_popped", q0.size(), 0);
        send(0, 8'h81, P_81, 1'b1);
        wait_frames(0, 4);
        repeat (60) @(negedge clk);
        check("no_residue_frames", frames[0], 4);

        // two stop bits
        send(1, 8'h55, P_55, 1'b1);
        measure(1, P_55.len() * BC);
        wait_frames(1, 1);

`ifdef UART_TX_PARITY_EN
        send(0, 8'h07, P_07, 1'b1);
        measure(0, 44);
        wait_frames(0, 5);
        send(0, 8'h03, P_03, 1'b1);
        measure(0, 44);
        wait_frames(0, 6);
`endif

        repeat (10) @(negedge clk);
        check("scoreboard_drained_u0", q0.size(), 0);
        check("scoreboard_drained_u1", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
